// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate extension pipeline.
package imm_ext_pkg;

    // Extension modes selectable on in_mode.
    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

    // Word-to-byte offset scaling applied to branch immediates.
    localparam int unsigned BRANCH_SHIFT = 2;

endpackage

// File: rtl/ext_buf2.sv
// Two-entry FIFO with valid/ready handshake on both sides.
// Slot 0 is always the head, so the output is a plain register read.
module ext_buf2 #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       r_count;
    logic [1:0]       w_count_d;
    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic [WIDTH-1:0] w_slot0_d;
    logic [WIDTH-1:0] w_slot1_d;
    logic             w_push;
    logic             w_pop;

    // Ready/valid come straight from the occupancy register; no path from out_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_slot0;

    // flush wins over both handshakes.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    // Next-state for occupancy and the two slots.
    always_comb begin
        w_count_d = r_count;
        w_slot0_d = r_slot0;
        w_slot1_d = r_slot1;
        if (flush) begin
            w_count_d = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        w_slot0_d = in_data;
                    end else begin
                        w_slot1_d = in_data;
                    end
                    w_count_d = r_count + 2'd1;
                end
                2'b01: begin
                    w_slot0_d = r_slot1;
                    w_count_d = r_count - 2'd1;
                end
                2'b11: begin
                    // Push only happens below full, so count is 1 here and the
                    // new entry becomes the head once the old head leaves.
                    w_slot0_d = in_data;
                end
                default: ;
            endcase
        end
    end

    // State registers; reset clears data too so the output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_count <= w_count_d;
            r_slot0 <= w_slot0_d;
            r_slot1 <= w_slot1_d;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension unit: combinational mode mux feeding a 2-entry
// registered output buffer. Only the extended word and tag are stored.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned EXT_W = OUT_W - IN_W;
    localparam int unsigned BUF_W = OUT_W + TAG_W;

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_ext;
    logic [BUF_W-1:0] w_head;

    assign w_sign = {{EXT_W{in_imm[IN_W-1]}}, in_imm};

    // Select the extended operand for the requested mode.
    always_comb begin
        w_ext = '0;
        case (ext_mode_t'(in_mode))
            EXT_ZERO:   w_ext = {{EXT_W{1'b0}}, in_imm};
            EXT_SIGN:   w_ext = w_sign;
            EXT_UPPER:  w_ext = {in_imm, {EXT_W{1'b0}}};
            EXT_BRANCH: w_ext = w_sign << BRANCH_SHIFT;
            default:    w_ext = '0;
        endcase
    end

    ext_buf2 #(
        .WIDTH(BUF_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({w_ext, in_tag}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_head)
    );

    assign out_data = w_head[TAG_W +: OUT_W];
    assign out_tag  = w_head[TAG_W-1:0];

endmodule
